// File: rtl/traffic_light_monitor.sv
// Passive checker for the traffic-light controller lamps: tracks the RED -> YELLOW -> GREEN ->
// YELLOW phase order and phase lengths, latches the first violation and counts clean cycles.
module traffic_light_monitor #(
    parameter int unsigned YELLOW = 2,
    parameter int unsigned GREEN  = 4,
    parameter int unsigned RED    = 6,
    parameter int unsigned CNT_W  = 8
) (
    input  logic        clk,
    input  logic        i_rst_n,
    input  logic        i_yellow,
    input  logic        i_green,
    input  logic        i_red,
    output logic        o_error,
    output logic [1:0]  o_err_code,
    output logic        o_cycle_done,
    output logic [15:0] o_cycles
);

    typedef enum logic [2:0] {
        StSync,
        StRed,
        StYUp,
        StGreen,
        StYDn,
        StFault
    } state_e;

    localparam logic [1:0] CodeIllegal = 2'd0;
    localparam logic [1:0] CodeOrder   = 2'd1;
    localparam logic [1:0] CodeShort   = 2'd2;
    localparam logic [1:0] CodeLong    = 2'd3;

    localparam logic [CNT_W-1:0] YLen = CNT_W'(YELLOW + 1);
    localparam logic [CNT_W-1:0] GLen = CNT_W'(GREEN + 1);
    localparam logic [CNT_W-1:0] RLen = CNT_W'(RED + 1);

    // Lamp vectors are ordered {red, yellow, green}.
    localparam logic [2:0] LampR = 3'b100;
    localparam logic [2:0] LampY = 3'b010;
    localparam logic [2:0] LampG = 3'b001;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             first_q, first_d;
    logic             lap_ok_q, lap_ok_d;
    logic             error_q, error_d;
    logic [1:0]       code_q, code_d;
    logic             done_q, done_d;
    logic [15:0]      cycles_q, cycles_d;

    logic [2:0]       lamps;
    logic [1:0]       lamp_cnt;
    logic             legal;
    logic [2:0]       cur_lamp;
    logic [2:0]       nxt_lamp;
    state_e           nxt_state;
    logic [CNT_W-1:0] phase_len;
    logic             raise;
    logic [1:0]       raise_code;

    assign lamps    = {i_red, i_yellow, i_green};
    assign lamp_cnt = {1'b0, i_red} + {1'b0, i_yellow} + {1'b0, i_green};
    assign legal    = (lamp_cnt == 2'd1);

    always_comb begin
        cur_lamp  = 3'b000;
        nxt_lamp  = 3'b000;
        nxt_state = StFault;
        phase_len = '0;
        case (state_q)
            StRed: begin
                cur_lamp  = LampR;
                nxt_lamp  = LampY;
                nxt_state = StYUp;
                phase_len = RLen;
            end
            StYUp: begin
                cur_lamp  = LampY;
                nxt_lamp  = LampG;
                nxt_state = StGreen;
                phase_len = YLen;
            end
            StGreen: begin
                cur_lamp  = LampG;
                nxt_lamp  = LampY;
                nxt_state = StYDn;
                phase_len = GLen;
            end
            StYDn: begin
                cur_lamp  = LampY;
                nxt_lamp  = LampR;
                nxt_state = StRed;
                phase_len = YLen;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        first_d    = first_q;
        lap_ok_d   = lap_ok_q;
        error_d    = error_q;
        code_d     = code_q;
        done_d     = 1'b0;
        cycles_d   = cycles_q;
        raise      = 1'b0;
        raise_code = CodeIllegal;

        case (state_q)
            StSync: begin
                if (legal && (i_red || i_green)) begin
                    state_d  = i_red ? StRed : StGreen;
                    cnt_d    = CNT_W'(1);
                    first_d  = 1'b1;
                    lap_ok_d = 1'b0;
                end
            end
            StFault: ;
            default: begin
                if (!legal) begin
                    raise      = 1'b1;
                    raise_code = CodeIllegal;
                end else if (lamps == cur_lamp) begin
                    // The unchecked first phase parks its counter at the limit instead of erroring.
                    if (cnt_q >= phase_len) begin
                        if (!first_q) begin
                            raise      = 1'b1;
                            raise_code = CodeLong;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (lamps != nxt_lamp) begin
                    raise      = 1'b1;
                    raise_code = CodeOrder;
                end else if (!first_q && (cnt_q < phase_len)) begin
                    raise      = 1'b1;
                    raise_code = CodeShort;
                end else begin
                    state_d = nxt_state;
                    cnt_d   = CNT_W'(1);
                    first_d = 1'b0;
                    // A lap only counts once its red phase has been length-checked.
                    if (state_q == StRed) begin
                        lap_ok_d = !first_q;
                    end
                    if (state_q == StYDn) begin
                        lap_ok_d = 1'b0;
                        if (lap_ok_q) begin
                            done_d = 1'b1;
                            if (cycles_q != 16'hFFFF) begin
                                cycles_d = cycles_q + 16'd1;
                            end
                        end
                    end
                end
            end
        endcase

        if (raise) begin
            state_d = StFault;
            error_d = 1'b1;
            code_d  = raise_code;
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= StSync;
            cnt_q    <= '0;
            first_q  <= 1'b0;
            lap_ok_q <= 1'b0;
            error_q  <= 1'b0;
            code_q   <= 2'd0;
            done_q   <= 1'b0;
            cycles_q <= 16'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            first_q  <= first_d;
            lap_ok_q <= lap_ok_d;
            error_q  <= error_d;
            code_q   <= code_d;
            done_q   <= done_d;
            cycles_q <= cycles_d;
        end
    end

    assign o_error      = error_q;
    assign o_err_code   = code_q;
    assign o_cycle_done = done_q;
    assign o_cycles     = cycles_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor with default durations (Y=3, G=5, R=7 cycles).
module tb_traffic_light_monitor;

    logic        clk;
    logic        i_rst_n;
    logic        i_yellow;
    logic        i_green;
    logic        i_red;
    logic        o_error;
    logic [1:0]  o_err_code;
    logic        o_cycle_done;
    logic [15:0] o_cycles;

    int n_cmp;
    int n_err;

    traffic_light_monitor #(
        .YELLOW(2),
        .GREEN (4),
        .RED   (6),
        .CNT_W (8)
    ) dut (
        .clk         (clk),
        .i_rst_n     (i_rst_n),
        .i_yellow    (i_yellow),
        .i_green     (i_green),
        .i_red       (i_red),
        .o_error     (o_error),
        .o_err_code  (o_err_code),
        .o_cycle_done(o_cycle_done),
        .o_cycles    (o_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one lamp sample, let the DUT take it, then settle just after the edge.
    task automatic step(input logic r, input logic y, input logic g);
        i_red    = r;
        i_yellow = y;
        i_green  = g;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic r, input logic y, input logic g, input int n);
        for (int i = 0; i < n; i++) step(r, y, g);
    endtask

    // Reset lands mid-cycle so the outputs must clear asynchronously.
    task automatic do_reset(input string tag);
        #3;
        i_rst_n = 1'b0;
        #1;
        chk({tag, "_rst_error"}, {15'd0, o_error}, 16'd0);
        chk({tag, "_rst_code"}, {14'd0, o_err_code}, 16'd0);
        chk({tag, "_rst_done"}, {15'd0, o_cycle_done}, 16'd0);
        chk({tag, "_rst_cycles"}, o_cycles, 16'd0);
        i_red    = 1'b0;
        i_yellow = 1'b0;
        i_green  = 1'b0;
        @(posedge clk);
        #1;
        i_rst_n = 1'b1;
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        i_rst_n  = 1'b1;
        i_red    = 1'b0;
        i_yellow = 1'b0;
        i_green  = 1'b0;
        @(posedge clk);
        #1;

        // Clean run: sync on red, first lap unchecked, then two counted laps 18 cycles apart.
        do_reset("clean");
        run(1, 0, 0, 3);
        run(0, 1, 0, 3);
        run(0, 0, 1, 5);
        run(0, 1, 0, 3);
        step(1, 0, 0);
        chk("clean_sync_lap_no_done", {15'd0, o_cycle_done}, 16'd0);
        run(1, 0, 0, 6);
        run(0, 1, 0, 3);
        run(0, 0, 1, 5);
        run(0, 1, 0, 3);
        step(1, 0, 0);
        chk("clean_lap1_done", {15'd0, o_cycle_done}, 16'd1);
        chk("clean_lap1_cycles", o_cycles, 16'd1);
        step(1, 0, 0);
        chk("clean_done_one_cycle", {15'd0, o_cycle_done}, 16'd0);
        run(1, 0, 0, 5);
        run(0, 1, 0, 3);
        run(0, 0, 1, 5);
        run(0, 1, 0, 3);
        step(1, 0, 0);
        chk("clean_lap2_done", {15'd0, o_cycle_done}, 16'd1);
        chk("clean_lap2_cycles", o_cycles, 16'd2);
        chk("clean_no_error", {15'd0, o_error}, 16'd0);

        // Green of 4 cycles (one short) followed by yellow.
        do_reset("short");
        run(1, 0, 0, 7);
        run(0, 1, 0, 3);
        run(0, 0, 1, 4);
        chk("short_before", {15'd0, o_error}, 16'd0);
        step(0, 1, 0);
        chk("short_error", {15'd0, o_error}, 16'd1);
        chk("short_code", {14'd0, o_err_code}, 16'd2);

        // Green held for 6 samples: the 5th is still legal, the 6th is too long.
        do_reset("long");
        run(1, 0, 0, 2);
        run(0, 1, 0, 3);
        run(0, 0, 1, 5);
        chk("long_at_limit", {15'd0, o_error}, 16'd0);
        step(0, 0, 1);
        chk("long_error", {15'd0, o_error}, 16'd1);
        chk("long_code", {14'd0, o_err_code}, 16'd3);

        // Red followed directly by green after one counted lap.
        do_reset("order");
        run(1, 0, 0, 2);
        run(0, 1, 0, 3);
        run(0, 0, 1, 5);
        run(0, 1, 0, 3);
        run(1, 0, 0, 7);
        run(0, 1, 0, 3);
        run(0, 0, 1, 5);
        run(0, 1, 0, 3);
        step(1, 0, 0);
        chk("order_cycles_before", o_cycles, 16'd1);
        run(1, 0, 0, 6);
        step(0, 0, 1);
        chk("order_error", {15'd0, o_error}, 16'd1);
        chk("order_code", {14'd0, o_err_code}, 16'd1);
        chk("order_cycles_frozen", o_cycles, 16'd1);

        // Yellow+red during green; later violations must not replace code 0.
        do_reset("illegal");
        run(0, 0, 1, 2);
        run(0, 1, 0, 3);
        run(1, 0, 0, 7);
        run(0, 1, 0, 3);
        run(0, 0, 1, 2);
        step(1, 1, 0);
        chk("illegal_error", {15'd0, o_error}, 16'd1);
        chk("illegal_code", {14'd0, o_err_code}, 16'd0);
        run(0, 0, 1, 10);
        step(1, 0, 0);
        step(0, 0, 0);
        chk("illegal_code_sticky", {14'd0, o_err_code}, 16'd0);
        chk("illegal_error_sticky", {15'd0, o_error}, 16'd1);
        step(0, 1, 0);

        // Reset mid-yellow after the fault, then ignored dark/yellow samples and a clean resync.
        do_reset("restart");
        run(0, 0, 0, 3);
        run(0, 1, 0, 2);
        chk("restart_sync_ignores", {15'd0, o_error}, 16'd0);
        run(1, 0, 0, 4);
        run(0, 1, 0, 3);
        run(0, 0, 1, 5);
        run(0, 1, 0, 3);
        step(1, 0, 0);
        chk("restart_sync_lap_no_done", {15'd0, o_cycle_done}, 16'd0);
        run(1, 0, 0, 6);
        run(0, 1, 0, 3);
        run(0, 0, 1, 5);
        run(0, 1, 0, 3);
        step(1, 0, 0);
        chk("restart_first_done", {15'd0, o_cycle_done}, 16'd1);
        chk("restart_cycles", o_cycles, 16'd1);
        chk("restart_no_error", {15'd0, o_error}, 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/traffic_light_monitor.md
# traffic_light_monitor

Passive checker on the lamp outputs of the traffic-light controller. It samples yellow/green/red every clock and tracks the expected phase sequence RED -> YELLOW -> GREEN -> YELLOW -> RED. It checks each phase length against the same duration parameters the controller uses. It reports the first violation with a sticky error code and counts completed light cycles. It sits beside the controller in the lab top level and in benches, and drives nothing back into the controller.

## Interface
- YELLOW, 2, yellow duration parameter; a yellow phase lasts YELLOW+1 cycles
- GREEN, 4, green duration parameter; a green phase lasts GREEN+1 cycles
- RED, 6, red duration parameter; a red phase lasts RED+1 cycles
- CNT_W, 8, phase counter width; must hold max(YELLOW,GREEN,RED)+2
- clk  input  1  clock, rising edge
- i_rst_n  input  1  asynchronous active-low reset
- i_yellow  input  1  yellow lamp from controller
- i_green  input  1  green lamp from controller
- i_red  input  1  red lamp from controller
- o_error  output  1  sticky error flag
- o_err_code  output  2  first error: 0 illegal lamp pattern, 1 wrong order, 2 phase too short, 3 phase too long
- o_cycle_done  output  1  one-cycle pulse when a full cycle completes cleanly
- o_cycles  output  16  completed clean cycles, saturating at 16'hFFFF

## Operation
- Lamp pattern is legal only when exactly one lamp is lit. All dark and multi-lit patterns are both illegal (code 0).
- States:
  - SYNC: after reset, lamps are ignored until red or green is sampled alone. That lamp becomes the current phase: red -> S_RED, green -> S_GREEN. The phase counter starts at 1. The length of this first phase is never checked.
  - S_RED: next expected phase is Y_UP.
  - Y_UP: yellow following red; next expected phase is S_GREEN.
  - S_GREEN: next expected phase is Y_DN.
  - Y_DN: yellow following green; next expected phase is S_RED.
  - FAULT: terminal state; left only by reset.
- Same lamp as the current phase: phase counter increments.
  - If the counter would exceed the phase length (N+1), raise error code 3. This is detected on the (N+2)-th sample.
- Different legal lamp:
  - If the lamp is not the expected next phase, raise code 1.
  - Else if the counter is less than N+1 and the phase is not the first one after SYNC, raise code 2.
  - Else move to the next state and load the counter with 1.
- Illegal pattern in any state except SYNC: raise code 0. In SYNC, illegal patterns are ignored.
- Check priority within one sample: illegal pattern > order > short > long.
- Raising an error:
  - o_error is set and o_err_code is loaded; both hold until reset.
  - The state goes to FAULT; counting and o_cycles freeze.
- Clean cycle: Y_DN -> S_RED taken with a full-length Y_DN and a checked S_GREEN, Y_UP and S_RED in the same lap.
  - On that transition, o_cycle_done pulses for one cycle and o_cycles increments (saturating).
  - A lap that started in SYNC does not count unless its red phase was checked. The first clean pulse is therefore at the end of the first fully observed red-yellow-green-yellow sequence.

## Timing
- All outputs are registered. Inputs are sampled at each rising edge of clk.
- Error latency: o_error and o_err_code are valid in the cycle after the edge that samples the offending pattern.
  - Too long: fires on the edge sampling the (N+2)-th identical lamp.
  - Too short, order and illegal: fire on the edge sampling the new pattern.
- o_cycle_done is high for exactly the one cycle after the edge that samples red following a full Y_DN.
- Reset values (asynchronous, while i_rst_n=0): state SYNC, counter 0, o_error 0, o_err_code 0, o_cycle_done 0, o_cycles 0.
- Reset asserted mid-phase or in FAULT: immediate return to the reset values, then resynchronise through SYNC.
- Boundary: a phase of exactly N+1 cycles is legal; N and N+2 cycles are errors. With the default parameters a full cycle is 3+5+3+7 = 18 cycles.

## Test plan
- Controller with default parameters, run 3 full cycles after reset -> o_error stays 0. o_cycle_done pulses once per 18 cycles; o_cycles reaches at least 2.
- Forced sequence red(7), yellow(3), green(4), yellow -> o_error=1 and o_err_code=2 one cycle after the yellow is sampled.
- Forced green held for 6 cycles after a valid yellow -> code 3 one cycle after the 6th green sample.
- Forced red(7) followed directly by green -> code 1; o_cycles unchanged.
- Forced yellow+red together during S_GREEN -> code 0. Later errors do not overwrite the code; it stays 0.
- Reset pulse mid-yellow after an error -> all outputs read 0. In SYNC, all-dark and leading-yellow samples are ignored. A clean restart produces its first o_cycle_done after red/green sync and then the first complete checked red-yellow-green-yellow lap.
